// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - opcodes, defaults, flag bundle and op classification for the add/sub pipeline
//
// Shared by pipelined_addsub_unit and addsub_chunk_stage. Opcodes are held as
// 32-bit values so that callers with any OP_LEN can compare after a
// zero-extending cast.
package addsub_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int OP_LEN_DEF = 5;

  localparam int unsigned OP_ADD  = 32'd1;
  localparam int unsigned OP_ADDS = 32'd2;
  localparam int unsigned OP_SUB  = 32'd3;
  localparam int unsigned OP_ADDC = 32'd4;
  localparam int unsigned OP_SUBB = 32'd5;
  localparam int unsigned OP_CMP  = 32'd6;

  typedef struct packed {
    logic cout;
    logic neg;
    logic ovf;
    logic zero;
  } flags_t;

  // Ops whose retirement writes the architectural carry register.
  function automatic logic updates_carry(input int unsigned op);
    return (op == OP_ADD) || (op == OP_ADDS) || (op == OP_SUB) ||
           (op == OP_ADDC) || (op == OP_SUBB);
  endfunction

  // Ops whose carry-in comes from the architectural carry register.
  function automatic logic reads_carry(input int unsigned op);
    return (op == OP_ADDC) || (op == OP_SUBB);
  endfunction

endpackage

// File: rtl/addsub_chunk_stage.sv
// rtl/addsub_chunk_stage.sv - one CHUNK-wide adder slice plus its pipeline register
//
// Adds bits [IDX*CHUNK +: CHUNK] of the carried operands using the incoming
// carry, merges the chunk into the partial sum and registers everything.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             clears the stage valid on the next edge
//   hold              freezes the register (downstream stall)
//   in_*              op state from the previous stage (or the issue logic)
//   out_*             registered op state for the next stage / result
module addsub_chunk_stage #(
  parameter int WIDTH  = 32,
  parameter int OP_LEN = 5,
  parameter int CHUNK  = 8,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [OP_LEN-1:0] in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_bx,
  input  logic [WIDTH-1:0]  in_sum,
  input  logic              in_carry,
  input  logic              in_zero,
  output logic              out_valid,
  output logic [OP_LEN-1:0] out_op,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_bx,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_carry,
  output logic              out_zero
);

  localparam int LSB = IDX * CHUNK;

  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] sum_next;

  assign chunk_res = {1'b0, in_a[LSB +: CHUNK]} + {1'b0, in_bx[LSB +: CHUNK]} +
                     {{CHUNK{1'b0}}, in_carry};

  always_comb begin
    sum_next = in_sum;
    sum_next[LSB +: CHUNK] = chunk_res[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_a     <= '0;
      out_bx    <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!hold) begin
      out_valid <= in_valid;
      out_op    <= in_op;
      out_a     <= in_a;
      out_bx    <= in_bx;
      out_sum   <= sum_next;
      out_carry <= chunk_res[CHUNK];
      out_zero  <= in_zero && (chunk_res[CHUNK-1:0] == '0);
    end
  end

endmodule

// File: rtl/pipelined_addsub_unit.sv
// rtl/pipelined_addsub_unit.sv - pipelined add/sub/compare unit with valid/ready and carry register
//
// WIDTH-bit add/subtract split into STAGES carry-chained chunks; the last
// stage register is the output register, so a result is valid STAGES cycles
// after acceptance. STAGES must divide WIDTH.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      drop all in-flight ops and clear carry_q
//   in_valid/in_ready          issue handshake for a, b, opcode
//   out_valid/out_ready        result handshake for final_sum and flags
//   cout, negative_flag, overflow_flag, zero_flag   result flags
//   carry_q                    architectural carry for ADDC/SUBB
//   busy                       any stage holds a valid op
module pipelined_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int OP_LEN = OP_LEN_DEF,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [OP_LEN-1:0] opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  final_sum,
  output logic              cout,
  output logic              negative_flag,
  output logic              overflow_flag,
  output logic              zero_flag,
  output logic              carry_q,
  output logic              busy
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic              st_valid [STAGES];
  logic              st_carry [STAGES];
  logic              st_zero  [STAGES];
  logic [OP_LEN-1:0] st_op    [STAGES];
  logic [WIDTH-1:0]  st_a     [STAGES];
  logic [WIDTH-1:0]  st_bx    [STAGES];
  logic [WIDTH-1:0]  st_sum   [STAGES];

  logic             stall;
  logic             interlock;
  logic             pending_carry;
  logic             accept;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_bx;
  logic             s0_cin;
  flags_t           flags;

  assign stall = out_valid && !out_ready;

  // An ADDC/SUBB must wait until no op that will still write carry_q is in
  // flight, including one sitting in the output register.
  always_comb begin
    pending_carry = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (st_valid[k] && updates_carry(32'(st_op[k]))) begin
        pending_carry = 1'b1;
      end
    end
  end

  assign interlock = in_valid && reads_carry(32'(opcode)) && pending_carry;
  assign in_ready  = !stall && !interlock && !flush;
  assign accept    = in_valid && in_ready;

  // Operand conditioning. Illegal opcodes are turned into 0+0+0, which yields
  // the required zero result with only zero_flag set.
  always_comb begin
    s0_a   = a;
    s0_bx  = b;
    s0_cin = 1'b0;
    case (32'(opcode))
      OP_ADD, OP_ADDS: ;
      OP_SUB, OP_CMP: begin
        s0_bx  = ~b;
        s0_cin = 1'b1;
      end
      OP_ADDC: s0_cin = carry_q;
      OP_SUBB: begin
        s0_bx  = ~b;
        s0_cin = carry_q;
      end
      default: begin
        s0_a  = '0;
        s0_bx = '0;
      end
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              in_v;
    logic              in_c;
    logic              in_z;
    logic [OP_LEN-1:0] in_op;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_bx;
    logic [WIDTH-1:0]  in_sum;

    if (k == 0) begin : g_head
      assign in_v   = accept;
      assign in_op  = opcode;
      assign in_a   = s0_a;
      assign in_bx  = s0_bx;
      assign in_sum = '0;
      assign in_c   = s0_cin;
      assign in_z   = 1'b1;
    end else begin : g_tail
      assign in_v   = st_valid[k-1];
      assign in_op  = st_op[k-1];
      assign in_a   = st_a[k-1];
      assign in_bx  = st_bx[k-1];
      assign in_sum = st_sum[k-1];
      assign in_c   = st_carry[k-1];
      assign in_z   = st_zero[k-1];
    end

    addsub_chunk_stage #(
      .WIDTH  (WIDTH),
      .OP_LEN (OP_LEN),
      .CHUNK  (CHUNK),
      .IDX    (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .hold      (stall),
      .in_valid  (in_v),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_bx     (in_bx),
      .in_sum    (in_sum),
      .in_carry  (in_c),
      .in_zero   (in_z),
      .out_valid (st_valid[k]),
      .out_op    (st_op[k]),
      .out_a     (st_a[k]),
      .out_bx    (st_bx[k]),
      .out_sum   (st_sum[k]),
      .out_carry (st_carry[k]),
      .out_zero  (st_zero[k])
    );
  end

  // Carry into the MSB is recovered from the MSB sum bit: a ^ bx ^ cin.
  assign flags.cout = st_carry[LAST];
  assign flags.neg  = st_sum[LAST][WIDTH-1];
  assign flags.ovf  = st_carry[LAST] ^
                      (st_a[LAST][WIDTH-1] ^ st_bx[LAST][WIDTH-1] ^ st_sum[LAST][WIDTH-1]);
  assign flags.zero = st_zero[LAST];

  assign out_valid     = st_valid[LAST];
  assign final_sum     = st_sum[LAST];
  assign cout          = flags.cout;
  assign negative_flag = flags.neg;
  assign overflow_flag = flags.ovf;
  assign zero_flag     = flags.zero;

  // Low operand bits of the output register are only consumed by earlier stages.
  logic unused_low_operands;
  assign unused_low_operands = ^{st_a[LAST][WIDTH-2:0], st_bx[LAST][WIDTH-2:0]};

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      busy = busy | st_valid[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (flush) begin
      carry_q <= 1'b0;
    end else if (out_valid && out_ready && updates_carry(32'(st_op[LAST]))) begin
      carry_q <= flags.cout;
    end
  end

endmodule
